// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port sync memory between CPU port C and DMA port D.
// Latency: grant/mem strobe same cycle; read data returns READ_LATENCY cycles after issue.
// Backpressure: requester holds req until gnt; no issue while a read is outstanding.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternating priority instead of C-priority with D anti-starvation).
module mem_port_arbiter #(
   parameter int WIDTH        = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1,
   parameter int MAX_WAIT     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [WIDTH-1:0]      c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [WIDTH-1:0]      c_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0]      d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [WIDTH-1:0]      d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   output logic                  busy
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

   state_t           state_q, state_d;
   logic [2:0]       lat_cnt_q, lat_cnt_d;
   logic             owner_q, owner_d;      // 0 = port C, 1 = port D
   logic [WIDTH-1:0] c_rdata_q, d_rdata_q;
   logic             d_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_win_q;                        // 0 = C won last, 1 = D won last

   // D wins alone, or on contention when C took the most recent grant.
   assign d_win = d_req && (!c_req || !last_win_q);

   // Remember the most recent winner; reset to D so C takes the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_win_q <= 1'b1;
      else if (c_gnt) last_win_q <= 1'b0;
      else if (d_gnt) last_win_q <= 1'b1;
   end
`else
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
   logic [3:0] wait_cnt_q;

   // C has priority unless D has been denied WAIT_MAX consecutive idle cycles.
   assign d_win = d_req && (!c_req || (wait_cnt_q == WAIT_MAX));

   // Count D denials in IDLE; hold across read waits, clear on grant or withdrawal.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    wait_cnt_q <= '0;
      else if (!d_req || d_gnt)                      wait_cnt_q <= '0;
      else if (state_q == IDLE && wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 4'd1;
   end
`endif

   // Next-state, memory strobes, grants and read-return pulses.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      owner_d   = owner_q;
      c_gnt     = 1'b0;
      d_gnt     = 1'b0;
      c_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            if (c_req || d_req) begin
               mem_en = 1'b1;
               if (d_win) begin
                  d_gnt     = 1'b1;
                  mem_we    = d_we;
                  mem_addr  = d_addr;
                  mem_wdata = d_wdata;
               end else begin
                  c_gnt     = 1'b1;
                  mem_we    = c_we;
                  mem_addr  = c_addr;
                  mem_wdata = c_wdata;
               end
               if (!mem_we) begin
                  state_d   = RD_WAIT;
                  lat_cnt_d = LAT_INIT;
                  owner_d   = d_win;
               end
            end
         end
         RD_WAIT: begin
            busy      = 1'b1;
            lat_cnt_d = lat_cnt_q - 3'd1;
            if (lat_cnt_q == 3'd1) begin
               state_d = IDLE;
               if (owner_q) d_rvalid = 1'b1;
               else         c_rvalid = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latency counter and read owner registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         owner_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         owner_q   <= owner_d;
      end
   end

   // Capture returning read data for the owner so it holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (c_rvalid) c_rdata_q <= mem_rdata;
         if (d_rvalid) d_rdata_q <= mem_rdata;
      end
   end

   // Read data is visible in the rvalid cycle itself, then held.
   assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
   assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule
